// File: rtl/countdown_32_sync_pkg.sv
// Shared definitions for the countdown_32_sync block: state encoding,
// default count width and the load-target helper.
package countdown_32_sync_pkg;

    localparam int unsigned CD_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // A load of zero has nothing to count, so it reports completion at once.
    function automatic state_t load_target(input logic is_zero);
        return is_zero ? DONE : RUN;
    endfunction

endpackage

// File: rtl/dffe_ref_rise_sync.sv
// Single-bit rising-edge flop with enable and synchronous clear;
// clear wins over enable.
module dffe_ref_rise_sync (
    input  logic clk,
    input  logic en,
    input  logic clr,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/countdown_32_sync.sv
// Loadable down-counter with IDLE/RUN/DONE sequencing, a busy flag and a
// one-cycle done pulse; all state lives in dffe_ref_rise_sync bit cells.
module countdown_32_sync
    import countdown_32_sync_pkg::*;
#(
    parameter int unsigned WIDTH = CD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             count_en;
    logic             load_zero;

    assign load_zero = (load_val == '0);

    always_comb begin
        state_d  = IDLE;
        count_d  = count_q;
        count_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    count_d  = load_val;
                    count_en = 1'b1;
                    state_d  = load_target(load_zero);
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                if (load) begin
                    count_d  = load_val;
                    count_en = 1'b1;
                    state_d  = load_target(load_zero);
                end else if (en) begin
                    // Zero count in RUN should never occur; hold at 0 and finish.
                    if (count_q == '0) begin
                        state_d  = DONE;
                    end else begin
                        count_d  = count_q - WIDTH'(1);
                        count_en = 1'b1;
                        state_d  = (count_q == WIDTH'(1)) ? DONE : RUN;
                    end
                end else begin
                    state_d  = RUN;
                end
            end
            DONE: begin
                if (load) begin
                    count_d  = load_val;
                    count_en = 1'b1;
                    state_d  = load_target(load_zero);
                end else begin
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_count
        dffe_ref_rise_sync u_bit (
            .clk (clk),
            .en  (count_en),
            .clr (rst),
            .d   (count_d[i]),
            .q   (count_q[i])
        );
    end

    for (genvar i = 0; i < 2; i++) begin : g_state
        dffe_ref_rise_sync u_bit (
            .clk (clk),
            .en  (1'b1),
            .clr (rst),
            .d   (state_d[i]),
            .q   (state_q[i])
        );
    end

    assign out  = count_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule
